stack_1r1w_bank_ctrl: RTL and testbench
=======================================

STACK_1R1W_BANK_CTRL -- requirements
Module: stack_1r1w_bank_ctrl

Interface
REQ-001 SHALL take parameters (name, default, meaning): WIDTH 32 data bits; NUMADDR 1024 logical words; BITADDR 10 address bits; NUMWBNK 4 banks; BITWBNK 2 bank index bits; NUMWROW 256 rows per bank; BITWROW 8 row bits; SRAM_DELAY 2 bank read latency; FLOPOUT 0 extra output flop stage (0/1).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk in 1 clock; rst in 1 reset, synchronous, active-high
- write in 1 write request; wr_adr in BITADDR; bw in WIDTH bit-enable; din in WIDTH
- read in 1 read request; rd_adr in BITADDR
- ready out 1 init complete; rd_vld out 1 read data valid; rd_dout out WIDTH; err out 1 rejected request pulse
- mem_write out NUMWBNK; mem_wr_adr out NUMWBNK*BITWROW; mem_bw out NUMWBNK*WIDTH; mem_din out NUMWBNK*WIDTH
- mem_read out NUMWBNK; mem_rd_adr out NUMWBNK*BITWROW; mem_rd_dout in NUMWBNK*WIDTH

Function
REQ-003 SHALL map a logical address as bank = addr mod NUMWBNK and row = addr div NUMWBNK, valid for non-power-of-2 NUMWBNK.
REQ-004 SHALL implement FSM states INIT and RUN; reset enters INIT with init_row = 0.
REQ-005 In INIT, each cycle SHALL drive mem_write to all ones, every bank's row field = init_row, mem_bw to all ones, mem_din to 0; init_row increments by 1.
REQ-006 SHALL move INIT -> RUN the cycle after init_row = NUMWROW-1 is written; ready = 1 only in RUN.
REQ-007 SHALL ignore write/read in INIT: no mem strobe, no err, no rd_vld.
REQ-008 In RUN, an accepted write SHALL assert only mem_write[bank] in the same cycle (combinational) and place row, bw and din into that bank's slice.
REQ-009 In RUN, an accepted read SHALL assert only mem_read[bank] in the same cycle with row in that bank's slice.
REQ-010 A read and a write in the same cycle SHALL both be issued, regardless of bank or address; same-address read returns the bank's pre-write data.
REQ-011 A request with address >= NUMADDR SHALL be dropped (no strobe) and raise err for one cycle; a simultaneous bad read and bad write raise one err pulse.
REQ-012 SHALL carry per accepted read a valid bit and bank index through a SRAM_DELAY+FLOPOUT stage shift pipeline; rd_vld and rd_dout = mem_rd_dout slice of that bank appear exactly SRAM_DELAY+FLOPOUT cycles after the request.
REQ-013 SHALL sustain one read and one write per cycle with no bubbles; rd_vld order equals request order.
REQ-014 Unstrobed bank slices of address/bw/din outputs SHALL be 0.
REQ-015 rd_dout SHALL be 0 when rd_vld = 0.

Reset
REQ-016 On rst: state = INIT, init_row = 0, read pipeline valids cleared, ready = 0, rd_vld = 0, err = 0, rd_dout = 0.
REQ-017 rst during INIT SHALL restart at row 0; rst with reads in flight SHALL discard them (no rd_vld afterwards).
REQ-018 mem_write and mem_read SHALL be 0 in any cycle where rst = 1.

Structure
REQ-019 SHALL place the FSM state encoding and the default geometry constants in a shared package stack_1r1w_pkg.
REQ-020 SHALL use one combinational sub-module bank_addr_map (addr -> bank, row), instanced once for each of the read and write paths.

Verification
REQ-021 Reset release -> ready low 256 cycles; mem_write = 4'b1111 with rows 0..255; ready = 1 on the next cycle.
REQ-022 RUN: write wr_adr = 5, din = 0xDEADBEEF, bw = all ones -> mem_write = 4'b0010, bank1 row 1; read rd_adr = 5 next cycle -> mem_read = 4'b0010 row 1; rd_vld 2 cycles later with rd_dout = 0xDEADBEEF from the bank model.
REQ-023 Reads at addresses 0, 1, 2, 3 on consecutive cycles with a write to 4 each cycle -> rd_vld high 4 consecutive cycles, data in order, no stalls.
REQ-024 NUMADDR = 1000: read 1000 -> err = 1 for one cycle, mem_read = 0, no rd_vld; address 999 -> bank 3, row 249.
REQ-025 rst asserted when init_row = 100 -> next INIT cycle writes row 0; rst with 2 reads in flight -> no rd_vld for those reads.

Source files
------------

// File: rtl/stack_1r1w_pkg.sv
// Shared definitions for the 1R1W banked stack controller: default geometry
// and the controller state encoding.
package stack_1r1w_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_NUMADDR    = 1024;
    localparam int DEF_BITADDR    = 10;
    localparam int DEF_NUMWBNK    = 4;
    localparam int DEF_BITWBNK    = 2;
    localparam int DEF_NUMWROW    = 256;
    localparam int DEF_BITWROW    = 8;
    localparam int DEF_SRAM_DELAY = 2;
    localparam int DEF_FLOPOUT    = 0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/bank_addr_map.sv
// Splits a logical address into a bank index and a row within that bank.
// Uses true mod/div so bank counts that are not a power of two still work.
module bank_addr_map
    import stack_1r1w_pkg::*;
#(
    parameter int BITADDR = DEF_BITADDR,
    parameter int NUMWBNK = DEF_NUMWBNK,
    parameter int BITWBNK = DEF_BITWBNK,
    parameter int BITWROW = DEF_BITWROW
) (
    input  logic [BITADDR-1:0] addr,
    output logic [BITWBNK-1:0] bank,
    output logic [BITWROW-1:0] row
);

    assign bank = BITWBNK'(addr % NUMWBNK);
    assign row  = BITWROW'(addr / NUMWBNK);

endmodule

// File: rtl/stack_1r1w_bank_ctrl.sv
// Banked 1R1W memory controller: zero-fills every bank after reset, then
// steers one read and one write per cycle to the owning bank.
module stack_1r1w_bank_ctrl
    import stack_1r1w_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NUMADDR    = DEF_NUMADDR,
    parameter int BITADDR    = DEF_BITADDR,
    parameter int NUMWBNK    = DEF_NUMWBNK,
    parameter int BITWBNK    = DEF_BITWBNK,
    parameter int NUMWROW    = DEF_NUMWROW,
    parameter int BITWROW    = DEF_BITWROW,
    parameter int SRAM_DELAY = DEF_SRAM_DELAY,
    parameter int FLOPOUT    = DEF_FLOPOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic [BITADDR-1:0]         wr_adr,
    input  logic [WIDTH-1:0]           bw,
    input  logic [WIDTH-1:0]           din,
    input  logic                       read,
    input  logic [BITADDR-1:0]         rd_adr,
    output logic                       ready,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dout,
    output logic                       err,
    output logic [NUMWBNK-1:0]         mem_write,
    output logic [NUMWBNK*BITWROW-1:0] mem_wr_adr,
    output logic [NUMWBNK*WIDTH-1:0]   mem_bw,
    output logic [NUMWBNK*WIDTH-1:0]   mem_din,
    output logic [NUMWBNK-1:0]         mem_read,
    output logic [NUMWBNK*BITWROW-1:0] mem_rd_adr,
    input  logic [NUMWBNK*WIDTH-1:0]   mem_rd_dout
);

    localparam logic [BITADDR:0]   ADDR_LIMIT = (BITADDR+1)'(NUMADDR);
    localparam logic [BITWROW-1:0] LAST_ROW   = BITWROW'(NUMWROW - 1);

    ctrl_state_t        state, state_next;
    logic [BITWROW-1:0] init_row, init_row_next;

    logic [BITWBNK-1:0] wr_bank, rd_bank;
    logic [BITWROW-1:0] wr_row, rd_row;
    logic               running, wr_bad, rd_bad, wr_go, rd_go;

    bank_addr_map #(
        .BITADDR(BITADDR), .NUMWBNK(NUMWBNK), .BITWBNK(BITWBNK), .BITWROW(BITWROW)
    ) u_wr_map (
        .addr(wr_adr), .bank(wr_bank), .row(wr_row)
    );

    bank_addr_map #(
        .BITADDR(BITADDR), .NUMWBNK(NUMWBNK), .BITWBNK(BITWBNK), .BITWROW(BITWROW)
    ) u_rd_map (
        .addr(rd_adr), .bank(rd_bank), .row(rd_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_row <= '0;
        end else begin
            state    <= state_next;
            init_row <= init_row_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_row_next = init_row;
        if (state == ST_INIT) begin
            init_row_next = init_row + 1'b1;
            if (init_row == LAST_ROW) begin
                state_next = ST_RUN;
            end
        end
    end

    // Requests only count in RUN and never while reset is held.
    assign running = (state == ST_RUN) && !rst;
    assign wr_bad  = {1'b0, wr_adr} >= ADDR_LIMIT;
    assign rd_bad  = {1'b0, rd_adr} >= ADDR_LIMIT;
    assign wr_go   = running && write && !wr_bad;
    assign rd_go   = running && read && !rd_bad;
    assign err     = running && ((write && wr_bad) || (read && rd_bad));
    assign ready   = running;

    always_comb begin
        mem_write  = '0;
        mem_wr_adr = '0;
        mem_bw     = '0;
        mem_din    = '0;
        mem_read   = '0;
        mem_rd_adr = '0;
        if (!rst && state == ST_INIT) begin
            mem_write = '1;
            mem_bw    = '1;
            for (int b = 0; b < NUMWBNK; b++) begin
                mem_wr_adr[b*BITWROW +: BITWROW] = init_row;
            end
        end else begin
            if (wr_go) begin
                mem_write[wr_bank]                   = 1'b1;
                mem_wr_adr[wr_bank*BITWROW +: BITWROW] = wr_row;
                mem_bw[wr_bank*WIDTH +: WIDTH]       = bw;
                mem_din[wr_bank*WIDTH +: WIDTH]      = din;
            end
            if (rd_go) begin
                mem_read[rd_bank]                      = 1'b1;
                mem_rd_adr[rd_bank*BITWROW +: BITWROW] = rd_row;
            end
        end
    end

    // The bank tag travels with the valid so the returning slice can be picked.
    logic [SRAM_DELAY-1:0] vld_pipe;
    logic [BITWBNK-1:0]    bank_pipe [SRAM_DELAY];
    logic                  sram_vld;
    logic [BITWBNK-1:0]    sram_bank;
    logic [WIDTH-1:0]      sram_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_go;
            for (int i = 1; i < SRAM_DELAY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        bank_pipe[0] <= rd_bank;
        for (int i = 1; i < SRAM_DELAY; i++) begin
            bank_pipe[i] <= bank_pipe[i-1];
        end
    end

    assign sram_vld  = vld_pipe[SRAM_DELAY-1] && !rst;
    assign sram_bank = bank_pipe[SRAM_DELAY-1];
    assign sram_data = sram_vld ? mem_rd_dout[sram_bank*WIDTH +: WIDTH] : '0;

    generate
        if (FLOPOUT != 0) begin : g_flopout
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_vld  <= 1'b0;
                    rd_dout <= '0;
                end else begin
                    rd_vld  <= sram_vld;
                    rd_dout <= sram_data;
                end
            end
        end else begin : g_direct
            assign rd_vld  = sram_vld;
            assign rd_dout = sram_data;
        end
    endgenerate

endmodule

// File: tb/tb_stack_1r1w_bank_ctrl.sv
// Bench for stack_1r1w_bank_ctrl: behavioural bank memories, a flat logical
// memory model and an expected-read queue checked every cycle.
module tb_stack_1r1w_bank_ctrl;

    localparam int WIDTH      = 32;
    localparam int NUMADDR    = 1000;
    localparam int BITADDR    = 10;
    localparam int NUMWBNK    = 4;
    localparam int BITWBNK    = 2;
    localparam int NUMWROW    = 256;
    localparam int BITWROW    = 8;
    localparam int SRAM_DELAY = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       write, read;
    logic [BITADDR-1:0]         wr_adr, rd_adr;
    logic [WIDTH-1:0]           bw, din;
    logic                       ready, rd_vld, err;
    logic [WIDTH-1:0]           rd_dout;
    logic [NUMWBNK-1:0]         mem_write, mem_read;
    logic [NUMWBNK*BITWROW-1:0] mem_wr_adr, mem_rd_adr;
    logic [NUMWBNK*WIDTH-1:0]   mem_bw, mem_din, mem_rd_dout;

    always #5 clk = ~clk;

    stack_1r1w_bank_ctrl #(
        .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR), .NUMWBNK(NUMWBNK),
        .BITWBNK(BITWBNK), .NUMWROW(NUMWROW), .BITWROW(BITWROW),
        .SRAM_DELAY(SRAM_DELAY), .FLOPOUT(0)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .wr_adr(wr_adr), .bw(bw), .din(din),
        .read(read), .rd_adr(rd_adr), .ready(ready), .rd_vld(rd_vld),
        .rd_dout(rd_dout), .err(err), .mem_write(mem_write), .mem_wr_adr(mem_wr_adr),
        .mem_bw(mem_bw), .mem_din(mem_din), .mem_read(mem_read),
        .mem_rd_adr(mem_rd_adr), .mem_rd_dout(mem_rd_dout)
    );

    // Physical banks: two-cycle registered read, read-before-write on collision.
    logic [WIDTH-1:0] bank_mem [NUMWBNK][NUMWROW];
    logic [WIDTH-1:0] rd_s1 [NUMWBNK];
    logic [WIDTH-1:0] rd_s2 [NUMWBNK];

    always @(posedge clk) begin
        for (int b = 0; b < NUMWBNK; b++) begin
            if (mem_read[b])
                rd_s1[b] <= bank_mem[b][mem_rd_adr[b*BITWROW +: BITWROW]];
            rd_s2[b] <= rd_s1[b];
            if (mem_write[b])
                bank_mem[b][mem_wr_adr[b*BITWROW +: BITWROW]] <=
                    (bank_mem[b][mem_wr_adr[b*BITWROW +: BITWROW]] & ~mem_bw[b*WIDTH +: WIDTH]) |
                    (mem_din[b*WIDTH +: WIDTH] & mem_bw[b*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        mem_rd_dout = '0;
        for (int b = 0; b < NUMWBNK; b++) mem_rd_dout[b*WIDTH +: WIDTH] = rd_s2[b];
    end

    typedef struct {
        int               due;
        logic [WIDTH-1:0] data;
    } rd_exp_t;

    rd_exp_t          exp_q[$];
    logic [WIDTH-1:0] model [NUMADDR];
    int               cycle = 0;
    int               init_count = 0;
    int               checks = 0;
    int               passed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    endtask

    task automatic clear_model();
        for (int a = 0; a < NUMADDR; a++) model[a] = '0;
    endtask

    // One clock cycle: drive inputs, predict every output, compare, advance.
    task automatic step(input logic r_st, input logic w, input logic [BITADDR-1:0] wa,
                        input logic [WIDTH-1:0] wbw, input logic [WIDTH-1:0] wd,
                        input logic r, input logic [BITADDR-1:0] ra);
        logic [NUMWBNK-1:0]         e_write, e_read;
        logic [NUMWBNK*BITWROW-1:0] e_wadr, e_radr;
        logic [NUMWBNK*WIDTH-1:0]   e_bw, e_din;
        logic                       e_err, e_vld, w_ok, r_ok, run;
        logic [WIDTH-1:0]           e_dout;
        int                         wb, rb;

        rst = r_st; write = w; wr_adr = wa; bw = wbw; din = wd; read = r; rd_adr = ra;

        run  = !r_st && (init_count >= NUMWROW);
        w_ok = run && w && (int'(wa) < NUMADDR);
        r_ok = run && r && (int'(ra) < NUMADDR);
        wb   = int'(wa) % NUMWBNK;
        rb   = int'(ra) % NUMWBNK;

        e_write = '0; e_read = '0; e_wadr = '0; e_radr = '0; e_bw = '0; e_din = '0;
        if (!r_st && init_count < NUMWROW) begin
            e_write = '1;
            e_bw    = '1;
            e_wadr  = {NUMWBNK{BITWROW'(init_count)}};
        end
        if (w_ok) begin
            e_write = NUMWBNK'(1 << wb);
            e_wadr  = (NUMWBNK*BITWROW)'(int'(wa) / NUMWBNK) << (BITWROW * wb);
            e_bw    = (NUMWBNK*WIDTH)'(wbw) << (WIDTH * wb);
            e_din   = (NUMWBNK*WIDTH)'(wd) << (WIDTH * wb);
        end
        if (r_ok) begin
            e_read = NUMWBNK'(1 << rb);
            e_radr = (NUMWBNK*BITWROW)'(int'(ra) / NUMWBNK) << (BITWROW * rb);
        end
        e_err  = run && ((w && int'(wa) >= NUMADDR) || (r && int'(ra) >= NUMADDR));
        e_vld  = 1'b0;
        e_dout = '0;
        if (!r_st && exp_q.size() > 0 && exp_q[0].due == cycle) begin
            e_vld  = 1'b1;
            e_dout = exp_q[0].data;
        end

        #3;
        check("mem_write",  128'(mem_write),  128'(e_write));
        check("mem_wr_adr", 128'(mem_wr_adr), 128'(e_wadr));
        check("mem_bw",     128'(mem_bw),     128'(e_bw));
        check("mem_din",    128'(mem_din),    128'(e_din));
        check("mem_read",   128'(mem_read),   128'(e_read));
        check("mem_rd_adr", 128'(mem_rd_adr), 128'(e_radr));
        check("err",        128'(err),        128'(e_err));
        check("ready",      128'(ready),      128'(run));
        check("rd_vld",     128'(rd_vld),     128'(e_vld));
        check("rd_dout",    128'(rd_dout),    128'(e_dout));

        if (e_vld) void'(exp_q.pop_front());
        if (r_st) begin
            exp_q.delete();
            clear_model();
        end
        if (r_ok) exp_q.push_back('{due: cycle + SRAM_DELAY, data: model[ra]});
        if (w_ok) model[wa] = (model[wa] & ~wbw) | (wd & wbw);
        if (r_st) init_count = 0;
        else if (init_count < NUMWROW) init_count++;

        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Random traffic, with requests also offered during INIT to prove they are ignored.
    task automatic random_steps(input int n);
        logic [BITADDR-1:0] wa, ra;
        logic [WIDTH-1:0]   m;
        for (int i = 0; i < n; i++) begin
            wa = ($urandom_range(0, 7) == 0) ? BITADDR'($urandom_range(990, 1023))
                                            : BITADDR'($urandom_range(0, 23));
            ra = ($urandom_range(0, 7) == 0) ? BITADDR'($urandom_range(990, 1023))
                                            : BITADDR'($urandom_range(0, 23));
            m  = ($urandom_range(0, 1) == 0) ? '1 : WIDTH'($urandom);
            step(1'b0, $urandom_range(0, 3) != 0, wa, m, WIDTH'($urandom),
                 $urandom_range(0, 3) != 0, ra);
        end
    endtask

    initial begin
        clear_model();
        rst = 1'b1; write = 1'b0; read = 1'b0;
        wr_adr = '0; rd_adr = '0; bw = '0; din = '0;

        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);

        // Zero-fill sweep with requests offered that must be ignored.
        random_steps(NUMWROW);
        idle(1);

        step(1'b0, 1'b1, 10'd5, '1, 32'hDEADBEEF, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd5);
        idle(3);

        for (int a = 0; a < 4; a++)
            step(1'b0, 1'b1, 10'd4, '1, 32'hA5A50000 + 32'(a), 1'b1, BITADDR'(a));
        idle(3);

        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd1000);
        step(1'b0, 1'b1, 10'd1000, '1, 32'h11111111, 1'b1, 10'd1001);
        step(1'b0, 1'b1, 10'd999, '1, 32'hCAFEF00D, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd999);
        step(1'b0, 1'b1, 10'd7, 32'h0000FFFF, 32'h12345678, 1'b1, 10'd7);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd7);
        idle(3);

        random_steps(400);
        idle(3);

        // Reset in the middle of the zero-fill sweep.
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        random_steps(100);
        step(1'b1, 1'b1, 10'd3, '1, 32'h1, 1'b1, 10'd3);
        random_steps(NUMWROW + 1);
        idle(2);

        // Reset with two reads still in flight.
        step(1'b0, 1'b1, 10'd9, '1, 32'h99990000, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd9);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd10);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        random_steps(NUMWROW + 1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 10'd9);
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
